// File: rtl/pam_serializer.sv
// rtl/pam_serializer.sv - frame-paced PAM word serializer: FIFO bytes -> sdata/bclk/nsync
// Assembles BYTES_PER_WORD bytes per frame tick and shifts DATA_BITS of them out to the DAC.
`timescale 1ns/1ps
module pam_serializer #(
  parameter int CLKS_PER_FRAME = 1200,
  parameter int CLKS_PER_BCLK  = 12,
  parameter int DATA_BITS      = 24,
  parameter int BYTES_PER_WORD = 3,
  parameter int MSB_FIRST      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] sample,
  input  logic       empty,
  output logic       read,
  output logic       sdata,
  output logic       bclk,
  output logic       nsync,
  output logic       busy,
  output logic       underrun,
  output logic       frame_miss
);
  localparam int FW = $clog2(CLKS_PER_FRAME);
  localparam int CW = $clog2(CLKS_PER_BCLK);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int KW = $clog2(BYTES_PER_WORD + 1);
  localparam int WW = BYTES_PER_WORD * 8;
  localparam logic [FW-1:0] FRAME_LAST = FW'(CLKS_PER_FRAME - 1);
  localparam logic [CW-1:0] BCLK_LAST  = CW'(CLKS_PER_BCLK - 1);
  localparam logic [CW-1:0] BCLK_RISE  = CW'(CLKS_PER_BCLK / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
  localparam logic [KW-1:0] BYTE_CNT   = KW'(BYTES_PER_WORD);
  localparam logic [KW-1:0] BYTE_LAST  = KW'(BYTES_PER_WORD - 1);

  if (CLKS_PER_BCLK < 2 || (CLKS_PER_BCLK % 2) != 0 || DATA_BITS < 1 ||
      BYTES_PER_WORD < 1 || BYTES_PER_WORD > 4 || DATA_BITS > WW ||
      (MSB_FIRST != 0 && MSB_FIRST != 1) ||
      CLKS_PER_FRAME < DATA_BITS * CLKS_PER_BCLK + BYTES_PER_WORD + 3) begin : g_param_check
    $error("pam_serializer: parameter set out of range");
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state_q;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic                   tick;
  logic [KW-1:0]          rd_cnt_q, cap_cnt_q;
  logic                   cap_q;
  logic [WW-1:0]          word_q, word_d;
  logic [DATA_BITS-1:0]   ord_d, sreg_q;
  logic [BW-1:0]          bit_q;
  logic [CW-1:0]          ccnt_q;
  logic read_q, sdata_q, bclk_q, nsync_q, busy_q, underrun_q, frame_miss_q;

  assign tick   = (fcnt_q == FRAME_LAST);
  assign fcnt_d = tick ? '0 : fcnt_q + 1'b1;

  // A byte requested last cycle is on sample now; merge it so the word is usable this edge.
  always_comb begin
    word_d = word_q;
    for (int k = 0; k < BYTES_PER_WORD; k++) begin
      if (cap_q && cap_cnt_q == KW'(k)) word_d[8*k +: 8] = sample;
    end
  end

  // ord_d[0] is the first bit on the wire, so the shifter always moves toward bit 0.
  for (genvar i = 0; i < DATA_BITS; i++) begin : g_ord
    localparam int SRC = (MSB_FIRST != 0) ? (DATA_BITS - 1 - i) : i;
    assign ord_d[i] = word_d[SRC];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fcnt_q       <= '0;
      rd_cnt_q     <= '0;
      cap_cnt_q    <= '0;
      cap_q        <= 1'b0;
      word_q       <= '0;
      sreg_q       <= '0;
      bit_q        <= '0;
      ccnt_q       <= '0;
      read_q       <= 1'b0;
      sdata_q      <= 1'b0;
      bclk_q       <= 1'b1;
      nsync_q      <= 1'b1;
      busy_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_miss_q <= 1'b0;
    end else if (!enable) begin
      read_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_miss_q <= 1'b0;
    end else begin
      fcnt_q       <= fcnt_d;
      read_q       <= 1'b0;
      underrun_q   <= 1'b0;
      frame_miss_q <= 1'b0;
      cap_q        <= read_q;
      word_q       <= word_d;
      if (cap_q) cap_cnt_q <= cap_cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (tick) begin
            if (empty) begin
              underrun_q <= 1'b1;
            end else begin
              state_q   <= LOAD;
              busy_q    <= 1'b1;
              read_q    <= 1'b1;
              rd_cnt_q  <= KW'(1);
              cap_cnt_q <= '0;
            end
          end
        end
        LOAD: begin
          if (tick) frame_miss_q <= 1'b1;
          if (!empty && rd_cnt_q < BYTE_CNT) begin
            read_q   <= 1'b1;
            rd_cnt_q <= rd_cnt_q + 1'b1;
          end
          if (cap_q && cap_cnt_q == BYTE_LAST) begin
            state_q <= SHIFT;
            nsync_q <= 1'b0;
            bclk_q  <= 1'b0;
            sdata_q <= ord_d[0];
            sreg_q  <= ord_d >> 1;
            bit_q   <= '0;
            ccnt_q  <= '0;
          end
        end
        SHIFT: begin
          if (tick) frame_miss_q <= 1'b1;
          if (ccnt_q == BCLK_LAST) begin
            ccnt_q <= '0;
            if (bit_q == BIT_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              nsync_q <= 1'b1;
              bclk_q  <= 1'b1;
              sdata_q <= 1'b0;
            end else begin
              bit_q   <= bit_q + 1'b1;
              bclk_q  <= 1'b0;
              sdata_q <= sreg_q[0];
              sreg_q  <= sreg_q >> 1;
            end
          end else begin
            ccnt_q <= ccnt_q + 1'b1;
            if (ccnt_q == BCLK_RISE) bclk_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read       = read_q;
  assign sdata      = sdata_q;
  assign bclk       = bclk_q;
  assign nsync      = nsync_q;
  assign busy       = busy_q;
  assign underrun   = underrun_q;
  assign frame_miss = frame_miss_q;
endmodule
